ixc_assign_probe: RTL and testbench
===================================

# ixc_assign_probe

Parameterized W-bit signal-connect cell for the emulation partition: drives a destination net from a source net with zero latency. It supports a forced-value override and an optional clocked probe that snapshots the source and counts value changes. It is instantiated wherever a netlist-level continuous assignment (strobe/alias of port, reset or status nets) must be preserved as a distinct, observable cell. Positional instantiation order is `(dst, src, ...)`, so existing `#(W) (dst, src)` call sites bind unchanged.

## Interface
- W, default 1: data width of src/dst/frc_val/snap (≥1).
- CW, default 16: change-counter width (≥1).
- clk  in  1  probe clock; all probe state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all probe state immediately.
- dst  out  W  destination net (declared first, positional port 0).
- src  in  W  source net (declared second, positional port 1).
- frc  in  1  force enable; default-tie 0.
- frc_val  in  W  forced value driven on dst while frc=1.
- clr  in  1  synchronous clear of chg_cnt.
- snap  out  W  registered copy of src.
- chg  out  1  registered flag: src differed from snap at the last edge.
- chg_cnt  out  CW  saturating count of edges at which chg was set.

## Operation
- Data path, purely combinational: dst = frc ? frc_val : src. No clock, no reset dependence; dst follows src even during rst.
- Probe, sampled on each rising clk when rst=0:
  - snap <= src.
  - chg <= (src != snap), compared with the pre-edge snap.
  - if clr: chg_cnt <= 0; else if (src != snap) and chg_cnt != all-ones: chg_cnt <= chg_cnt + 1; else hold.
- Probe observes src, never frc_val; forcing does not count as a change.
- clr and a change in the same cycle: clear wins, count becomes 0. chg still reports 1.
- Counter saturates at 2^CW−1 and does not wrap; clr is the only way out.
- X on src propagates to dst unchanged. There is no X-masking.

## Timing
- dst: 0-cycle latency, combinational from src, frc and frc_val.
- snap/chg/chg_cnt: 1-cycle latency from src at a rising clk.
- Reset values: snap=0, chg=0, chg_cnt=0. Asserted asynchronously on rst rise. Release is synchronous-safe: the first edge with rst=0 samples normally.
- First edge after reset compares src against snap=0. A non-zero src there counts as a change.
- Reset mid-operation discards the count immediately. dst is unaffected.

## Configuration
- Macro IXC_ASSIGN_PROBE_EN.
  - Defined: probe registers snap/chg/chg_cnt are built as specified.
  - Undefined: no flops are inferred. snap, chg and chg_cnt are tied to 0. clk, rst and clr are ignored. The dst/frc path is identical in both builds.
- Port list is the same with and without the macro.

## Test plan
- W=64, frc=0, src=64'hDEAD_BEEF_0123_4567 → dst equals src in the same delta, with no clock edge applied.
- frc=1, frc_val=8'hA5, src toggles 00/FF → dst holds A5. chg_cnt counts src toggles (e.g. 4 edges → 4).
- rst=1, src=1 for 3 edges, then rst=0, src held at 1 → edge 1 gives chg=1 and chg_cnt=1. Edge 2 gives chg=0 and chg_cnt=1.
- CW=2, src alternates each edge for 6 edges → chg_cnt reads 1,2,3,3,3,3. Then clr=1 with a toggle → chg_cnt=0 and chg=1.
- Assert rst asynchronously between edges with chg_cnt=5 → chg_cnt, snap and chg read 0 before the next edge. dst still tracks src.
- Build without IXC_ASSIGN_PROBE_EN, toggle src for 10 edges → snap, chg and chg_cnt stay 0. dst tracks src.

Source files
------------

// File: rtl/ixc_assign_probe.sv
// ixc_assign_probe: zero-latency dst<=src connect cell with force override and optional probe (IXC_ASSIGN_PROBE_EN)
module ixc_assign_probe #(
  parameter int W  = 1,
  parameter int CW = 16
) (
  output logic [W-1:0]  dst,
  input  logic [W-1:0]  src,
  input  logic          frc,
  input  logic [W-1:0]  frc_val,
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [W-1:0]  snap,
  output logic          chg,
  output logic [CW-1:0] chg_cnt
);
  // combinational data path, independent of clock and reset
  always_comb dst = frc ? frc_val : src;
`ifdef IXC_ASSIGN_PROBE_EN
  logic diff;
  always_comb diff = src != snap;
  // probe: snapshot src, flag changes, saturating change count with clear priority
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      snap    <= '0;
      chg     <= 1'b0;
      chg_cnt <= '0;
    end else begin
      snap    <= src;
      chg     <= diff;
      chg_cnt <= clr ? '0 : (diff && chg_cnt != '1) ? chg_cnt + 1'b1 : chg_cnt;
    end
`else
  logic unused_probe;
  always_comb unused_probe = ^{clk, rst, clr};
  // probe disabled: outputs held at zero, no state
  always_comb begin
    snap    = '0;
    chg     = 1'b0;
    chg_cnt = '0;
  end
`endif
endmodule

// File: tb/tb_ixc_assign_probe.sv
// tb_ixc_assign_probe: randomized + directed checks of ixc_assign_probe against a behavioural model
module tb_ixc_assign_probe;
`ifdef IXC_ASSIGN_PROBE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam int MAX = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] src = '0, frc_val = '0, dst, snap;
  logic frc = 1'b0, clr = 1'b0, chg;
  logic [1:0] chg_cnt;
  logic [63:0] src64 = '0, frc_val64 = '0, dst64, snap64;
  logic frc64 = 1'b0, chg64;
  logic [15:0] cnt64;
  int ntot = 0, npass = 0;
  logic [7:0] m_snap = '0;
  bit m_chg = 1'b0;
  int m_cnt = 0;

  ixc_assign_probe #(.W(8), .CW(2)) dut (
    .dst(dst), .src(src), .frc(frc), .frc_val(frc_val), .clk(clk), .rst(rst),
    .clr(clr), .snap(snap), .chg(chg), .chg_cnt(chg_cnt)
  );
  ixc_assign_probe #(.W(64), .CW(16)) dut64 (
    .dst(dst64), .src(src64), .frc(frc64), .frc_val(frc_val64), .clk(clk), .rst(rst),
    .clr(clr), .snap(snap64), .chg(chg64), .chg_cnt(cnt64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // behavioural model of the probe: a change is src differing from the last snapshot
  always @(posedge clk or posedge rst)
    if (rst || !EN) begin
      m_snap <= '0;
      m_chg  <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_snap <= src;
      m_chg  <= (src != m_snap);
      m_cnt  <= clr ? 0 : (src != m_snap) ? ((m_cnt + 1 > MAX) ? MAX : m_cnt + 1) : m_cnt;
    end

  // every cycle, away from the clock edge
  always @(negedge clk) begin
    chk("dst", dst, frc ? frc_val : src);
    chk("snap", snap, m_snap);
    chk("chg", chg, m_chg);
    chk("chg_cnt", chg_cnt, m_cnt);
  end

  task automatic step(input logic [7:0] s, input logic c);
    src = s;
    clr = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1;
    src64 = 64'hDEAD_BEEF_0123_4567;
    #0.5;
    chk("dst64_comb", dst64, 64'hDEAD_BEEF_0123_4567);
    frc64 = 1'b1;
    frc_val64 = 64'h0123_4567_89AB_CDEF;
    #0.5;
    chk("dst64_force", dst64, 64'h0123_4567_89AB_CDEF);
    src = 8'h01;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_snap", snap, 8'h00);
    chk("rst_cnt", chg_cnt, 2'd0);
    chk("dst_in_rst", dst, 8'h01);
    rst = 1'b0;
    step(8'h01, 1'b0);
    chk("edge1_chg", chg, EN);
    chk("edge1_cnt", chg_cnt, EN ? 2'd1 : 2'd0);
    chk("edge1_model", 64'(m_cnt), EN ? 64'd1 : 64'd0);
    step(8'h01, 1'b0);
    chk("edge2_chg", chg, 1'b0);
    chk("edge2_cnt", chg_cnt, EN ? 2'd1 : 2'd0);
    step(8'h01, 1'b1);
    chk("clr_cnt", chg_cnt, 2'd0);
    for (int i = 0; i < 6; i++) begin
      step(~src, 1'b0);
      chk("sat_cnt", chg_cnt, EN ? ((i < 3) ? 2'(i + 1) : 2'd3) : 2'd0);
    end
    step(~src, 1'b1);
    chk("clr_toggle_cnt", chg_cnt, 2'd0);
    chk("clr_toggle_chg", chg, EN);
    frc = 1'b1;
    frc_val = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      step((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b0);
      chk("frc_dst", dst, 8'hA5);
    end
    chk("frc_cnt", chg_cnt, EN ? 2'd3 : 2'd0);
    chk("frc_snap", snap, EN ? 8'h00 : 8'h00);
    rst = 1'b1;
    #1;
    chk("async_cnt", chg_cnt, 2'd0);
    chk("async_chg", chg, 1'b0);
    frc = 1'b0;
    src = 8'h3C;
    #1;
    chk("async_snap", snap, 8'h00);
    chk("async_dst", dst, 8'h3C);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      frc = ($urandom % 4) == 0;
      frc_val = 8'($urandom);
      rst = ($urandom % 40) == 0;
      step(($urandom % 2) ? 8'($urandom) : src, ($urandom % 8) == 0);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
